// File: rtl/mon_buf_arb.sv
// mon_buf_arb: arbiter and occupancy tracker for the single-port monitor trace
// buffer RAM. Round-robin between capture writer and UART reader, keeps the
// write pointer and entry count, and registers read data for the reader.
// Optional build macro MON_BUF_DROP_EN: writes while full are acknowledged and
// discarded, raising a sticky overflow flag (ovf, cleared by ovf_clr).
`timescale 1ns/1ps

module mon_buf_arb #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 18
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          wrreq,
  output logic          wrack,
  input  logic [DW-1:0] wdata,
  input  logic          rdreq,
  output logic          rdack,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          rd_pop,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
`ifdef MON_BUF_DROP_EN
  output logic          ovf,
  input  logic          ovf_clr,
`endif
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDWAIT,
    S_RDACK,
    S_WRITE_DROP
  } state_e;

  typedef enum logic {
    G_READ  = 1'b0,
    G_WRITE = 1'b1
  } grant_e;

  state_e          state_q;
  grant_e          last_q;
  logic [AW-1:0]   wptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   rdata_q;
  logic            wrack_q, rdack_q;
  logic            ram_cs_q, ram_we_q;
  logic [AW-1:0]   ram_addr_q;
  logic [DW-1:0]   ram_wdata_q;
  logic            full_c, wr_cand_c, drop_c, pick_wr_c, pick_rd_c, pop_c;

  // Arbitration candidates and next entry count
  always_comb begin
    full_c    = (count_q == CW'(DEPTH));
`ifdef MON_BUF_DROP_EN
    wr_cand_c = wrreq;
    drop_c    = wrreq & full_c;
`else
    wr_cand_c = wrreq & ~full_c;
    drop_c    = 1'b0;
`endif
    pick_wr_c = wr_cand_c & (~rdreq | (last_q == G_READ));
    pick_rd_c = rdreq & (~wr_cand_c | (last_q == G_WRITE));
    pop_c     = rd_pop & (count_q != '0);
    count_d   = count_q + CW'(state_q == S_WRITE) - CW'(pop_c);
  end

  // Access FSM with registered RAM strobes, acks and read data
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q     <= S_IDLE;
      last_q      <= G_READ;
      wptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      wrack_q     <= 1'b0;
      rdack_q     <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      wrack_q     <= 1'b0;
      rdack_q     <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      count_q     <= count_d;
      case (state_q)
        S_IDLE: begin
          if (pick_wr_c && drop_c) begin
            state_q <= S_WRITE_DROP;
            last_q  <= G_WRITE;
            wrack_q <= 1'b1;
          end else if (pick_wr_c) begin
            state_q     <= S_WRITE;
            last_q      <= G_WRITE;
            wrack_q     <= 1'b1;
            ram_cs_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= wptr_q;
            ram_wdata_q <= wdata;
          end else if (pick_rd_c) begin
            state_q    <= S_READ;
            last_q     <= G_READ;
            ram_cs_q   <= 1'b1;
            ram_addr_q <= raddr;
          end
        end
        S_WRITE: begin
          wptr_q  <= wptr_q + AW'(1);
          state_q <= S_IDLE;
        end
        S_READ:   state_q <= S_RDWAIT;
        S_RDWAIT: begin
          rdata_q <= ram_rdata;
          rdack_q <= 1'b1;
          state_q <= S_RDACK;
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MON_BUF_DROP_EN
  logic ovf_q;

  // Sticky overflow: a drop wins over a coincident clear
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) ovf_q <= 1'b0;
    else        ovf_q <= (state_q == S_WRITE_DROP) | (ovf_q & ~ovf_clr);
  end

  assign ovf = ovf_q;
`endif

  assign wrack     = wrack_q;
  assign rdack     = rdack_q;
  assign rdata     = rdata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = full_c;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
